// File: rtl/winograd_pkg.sv
// Shared types and constants for the Winograd F(4x4,3x3) transform units.
// Tiles are indexed [row][col]; all arithmetic wraps at DATA_W bits.
package winograd_pkg;

    localparam int DATA_W   = 32;
    localparam int TILE_IN  = 6;
    localparam int TILE_OUT = 4;

    typedef logic [DATA_W-1:0]        elem_t;
    typedef elem_t [0:TILE_IN-1]      vec6_t;
    typedef elem_t [0:TILE_OUT-1]     vec4_t;
    typedef vec6_t [0:TILE_IN-1]      m_tile_t;
    typedef vec6_t [0:TILE_OUT-1]     t_tile_t;
    typedef vec4_t [0:TILE_OUT-1]     y_tile_t;

    typedef enum logic [1:0] {
        IDLE,
        COL,
        ROW
    } state_e;

    localparam logic [2:0] CNT_COL_LAST = 3'd5;
    localparam logic [2:0] CNT_ROW_LAST = 3'd3;

endpackage

// File: rtl/winograd_output_transform_if.sv
// Tile-level start/done handshake and data tiles of the output transform.
// slave is the transform unit, master is the sequencing controller.
interface winograd_output_transform_if;
    import winograd_pkg::*;

    logic    start;
    m_tile_t tile_in;
    y_tile_t tile_out;
    logic    transform_done;

    modport master (
        output start,
        output tile_in,
        input  tile_out,
        input  transform_done
    );

    modport slave (
        input  start,
        input  tile_in,
        output tile_out,
        output transform_done
    );

endinterface

// File: rtl/at_vec_transform.sv
// Combinational A^T product of one 6-vector using shared add/sub terms.
// Shifts by 1, 2 and 3 stand in for the 2, 4 and 8 coefficients.
module at_vec_transform
    import winograd_pkg::*;
(
    input  vec6_t x_i,
    output vec4_t y_o
);

    elem_t s12, d12, s34, d34;

    assign s12 = x_i[1] + x_i[2];
    assign d12 = x_i[1] - x_i[2];
    assign s34 = x_i[3] + x_i[4];
    assign d34 = x_i[3] - x_i[4];

    assign y_o[0] = x_i[0] + s12 + s34;
    assign y_o[1] = d12 + (d34 << 1);
    assign y_o[2] = s12 + (s34 << 2);
    assign y_o[3] = d12 + (d34 << 3) + x_i[5];

endmodule

// File: rtl/winograd_output_transform.sv
// Winograd output transform Y = A^T * M * A, one column per cycle
// then one row per cycle through a single shared A^T vector unit.
module winograd_output_transform
    import winograd_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    winograd_output_transform_if.slave  io
);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    m_tile_t    m_q, m_d;
    t_tile_t    t_q, t_d;
    y_tile_t    out_q, out_d;
    logic       done_q, done_d;
    vec6_t      vin;
    vec4_t      vout;

    at_vec_transform u_at (
        .x_i (vin),
        .y_o (vout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            t_q     <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            t_q     <= t_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        t_d     = t_q;
        out_d   = out_q;
        done_d  = 1'b0;
        vin     = '0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    m_d     = io.tile_in;
                    cnt_d   = '0;
                    state_d = COL;
                end
            end
            COL: begin
                for (int k = 0; k < TILE_IN; k++) begin
                    vin[k] = m_q[k][cnt_q];
                end
                for (int r = 0; r < TILE_OUT; r++) begin
                    t_d[r][cnt_q] = vout[r];
                end
                if (cnt_q == CNT_COL_LAST) begin
                    cnt_d   = '0;
                    state_d = ROW;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ROW: begin
                // A^T applied to a row of T yields that row of T*A
                vin               = t_q[cnt_q[1:0]];
                out_d[cnt_q[1:0]] = vout;
                if (cnt_q == CNT_ROW_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign io.tile_out       = out_q;
    assign io.transform_done = done_q;

endmodule

// File: tb/tb_winograd_output_transform.sv
// Scoreboard bench for winograd_output_transform: directed tiles in,
// expected tiles queued, monitor compares on every done pulse.
module tb_winograd_output_transform;
    import winograd_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   tiles;

    y_tile_t exp_q[$];

    winograd_output_transform_if io();

    winograd_output_transform dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse consumes one queued expected tile
    always @(negedge clk) begin
        if (io.transform_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, expected no tile");
            end else begin
                y_tile_t e;
                e = exp_q.pop_front();
                for (int r = 0; r < 4; r++)
                    for (int j = 0; j < 4; j++)
                        check($sformatf("tile%0d_Y[%0d][%0d]", tiles, r, j),
                              io.tile_out[r][j], e[r][j]);
                tiles++;
            end
        end
    end

    // Reference Y = A^T M A with plain integer coefficients
    function automatic y_tile_t model(input m_tile_t m);
        int at[4][6] = '{
            '{1, 1,  1, 1,  1, 0},
            '{0, 1, -1, 2, -2, 0},
            '{0, 1,  1, 4,  4, 0},
            '{0, 1, -1, 8, -8, 1}
        };
        y_tile_t y;
        int acc;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int a = 0; a < 6; a++)
                    for (int b = 0; b < 6; b++)
                        acc = acc + at[r][a] * int'(m[a][b]) * at[j][b];
                y[r][j] = acc;
            end
        return y;
    endfunction

    task automatic run(input string name, input m_tile_t m,
                       input y_tile_t e, input bit mid_start);
        int n;
        @(negedge clk);
        io.tile_in = m;
        io.start   = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        io.start   = 1'b0;
        io.tile_in = '1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (mid_start)
                io.start = (n == 3);
        end while (io.transform_done !== 1'b1 && n < 20);
        io.start = 1'b0;
        check({name, "_done_latency"}, n, 10);
        @(posedge clk);
        #1;
        check({name, "_done_width"}, {31'd0, io.transform_done}, 0);
    endtask

    m_tile_t m, m2;
    y_tile_t e, e2;
    int      n;
    int      v[4];

    initial begin
        checks     = 0;
        errors     = 0;
        tiles      = 0;
        rst_n      = 1'b0;
        io.start   = 1'b0;
        io.tile_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {31'd0, io.transform_done}, 0);
        check("reset_tile_out_or", {31'd0, |io.tile_out}, 0);
        rst_n = 1'b1;

        // Single 1 at M[2][2]: Y = a*a^T with a = [1 -1 1 -1]
        m = '0;
        m[2][2] = 32'd1;
        v = '{1, -1, 1, -1};
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                e[r][j] = v[r] * v[j];
        run("delta22", m, e, 1'b0);

        // All ones: Y = v*v^T with v = A^T row sums [5 0 10 1]
        m = '1;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                m[r][c] = 32'd1;
        v = '{5, 0, 10, 1};
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                e[r][j] = v[r] * v[j];
        run("ones", m, e, 1'b0);

        m = '0;
        m[0][0] = 32'd1;
        e = '0;
        e[0][0] = 32'd1;
        run("corner00", m, e, 1'b0);

        m = '0;
        m[5][5] = 32'd1;
        e = '0;
        e[3][3] = 32'd1;
        run("corner55", m, e, 1'b0);

        m = '0;
        for (int k = 0; k < 6; k++)
            m[k][k] = k + 1;
        e = model(m);
        check("diag_model_Y00", e[0][0], 32'd15);
        check("diag_model_Y11", e[1][1], 32'd41);
        check("diag_model_Y33", e[3][3], 32'd587);
        run("diag", m, e, 1'b0);

        // Column 3 of A^T is [1 2 4 8]: Y[r][j] = 2^28 << (r+j), wrapping
        m = '0;
        m[3][3] = 32'h1000_0000;
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                e[r][j] = 32'h1000_0000 << (r + j);
        run("wrap", m, e, 1'b0);

        m = '0;
        m[1][4] = 32'd3;
        m[4][1] = 32'hFFFF_FFFE;
        m[3][0] = 32'd7;
        e = model(m);
        run("midstart", m, e, 1'b1);

        // Back-to-back: start held across the done cycle
        m = '0;
        m[2][2] = 32'd1;
        v = '{1, -1, 1, -1};
        for (int r = 0; r < 4; r++)
            for (int j = 0; j < 4; j++)
                e[r][j] = v[r] * v[j];
        m2 = '0;
        for (int k = 0; k < 6; k++)
            m2[k][k] = k + 1;
        e2 = model(m2);
        @(negedge clk);
        io.tile_in = m;
        io.start   = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        io.tile_in = m2;
        exp_q.push_back(e2);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (io.transform_done !== 1'b1 && n < 20);
        check("b2b_first_latency", n, 10);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                io.start   = 1'b0;
                io.tile_in = '0;
            end
        end while (io.transform_done !== 1'b1 && n < 20);
        check("b2b_done_spacing", n, 11);

        // Reset pulse during ROW: tile lost, no done, outputs cleared
        m = '0;
        m[2][2] = 32'd5;
        @(negedge clk);
        io.tile_in = m;
        io.start   = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_tile_out_or", {31'd0, |io.tile_out}, 0);
        n = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (io.transform_done === 1'b1)
                n++;
        end
        check("rst_no_done", n, 0);

        m = '0;
        m[0][0] = 32'd9;
        e = '0;
        e[0][0] = 32'd9;
        run("after_rst", m, e, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("tiles_seen", tiles, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
